act_writeback: RTL and testbench
================================

ACT_WRITEBACK -- requirements
Module: act_writeback

Interface
REQ-001 SHALL have parameter dataWidth, default 32, activation word width.
REQ-002 SHALL have parameter addrWidth, default 12, buffer address width.
REQ-003 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle pulse that begins a layer writeback.
REQ-006 SHALL have port num_vertices  input  16  vertex count, sampled on start.
REQ-007 SHALL have port feat_len  input  10  elements per vertex, sampled on start.
REQ-008 SHALL have port base_addr  input  addrWidth  first activation and mask address, sampled on start.
REQ-009 SHALL have port a_valid  input  1  ReLU output beat valid.
REQ-010 SHALL have port a  input  dataWidth  ReLU output activation.
REQ-011 SHALL have port a_ready  output  1  beat accepted when a_valid && a_ready.
REQ-012 SHALL have ports act_we (1), act_addr (addrWidth), act_wdata (dataWidth), all outputs, forming the activation buffer write port.
REQ-013 SHALL have ports mask_we (1), mask_addr (addrWidth), mask_wdata (32), all outputs, forming the ReLU-mask buffer write port.
REQ-014 SHALL have ports busy and done, both output, 1 bit each.

Function
REQ-015 SHALL implement FSM IDLE -> RUN on start; RUN -> FLUSH on acceptance of the last element of a vertex; FLUSH -> RUN if vertices remain, else FLUSH -> DONE; DONE -> IDLE unconditionally.
REQ-016 SHALL ignore start outside IDLE.
REQ-017 SHALL, on start with num_vertices==0 or feat_len==0, go to DONE without any write.
REQ-018 SHALL drive a_ready=1 only in RUN.
REQ-019 SHALL, one cycle after each accepted beat, assert act_we for one cycle with act_wdata=a and act_addr=base_addr+global element index (index 0 first).
REQ-020 SHALL form mask bit = (a != 0), packed LSB-first into a 32-bit accumulator.
REQ-021 SHALL write a mask word (mask_we for one cycle) one cycle after the 32nd bit accumulates, and in FLUSH for a partial word, with unused upper bits 0; no mask write in FLUSH if the accumulator is empty.
REQ-022 SHALL start every vertex's mask at bit 0 of a new word; mask_addr = base_addr + mask word count.
REQ-023 SHALL wrap all addresses modulo 2^addrWidth.
REQ-024 SHALL pulse done for exactly one cycle in DONE; busy=1 in RUN and FLUSH.
REQ-025 SHALL hold all write outputs at 0 when their write enable is deasserted.

Reset
REQ-026 SHALL, while rst==0, force state IDLE, all counters, accumulator and every output to 0, regardless of clk.
REQ-027 SHALL, on reset mid-operation, discard partial mask data and issue no further writes until the next start.

Configuration
REQ-028 SHALL, with macro ACT_WRITEBACK_MASK_EN defined, implement the mask path per REQ-020 to REQ-022.
REQ-029 SHALL, without ACT_WRITEBACK_MASK_EN, tie mask_we, mask_addr, mask_wdata to 0 and skip FLUSH (last beat of final vertex goes directly to DONE, otherwise stays in RUN); activation writes unchanged.

Verification
REQ-030 SHALL cover: num_vertices=1, feat_len=4, base_addr=0x100, a={0x3F800000,0,0x40000000,0} continuous -> act writes 0x100..0x103 in order, mask_wdata=0x00000005 at 0x100, done one cycle after FLUSH.
REQ-031 SHALL cover: num_vertices=1, feat_len=40, all a nonzero -> mask words 0xFFFFFFFF at base, 0x000000FF at base+1.
REQ-032 SHALL cover: num_vertices=2, feat_len=3, a_valid toggling every other cycle -> 6 act writes, 2 mask writes, a_ready=0 in each FLUSH cycle.
REQ-033 SHALL cover: base_addr=0xFFE, num_vertices=1, feat_len=4 -> act_addr 0xFFE,0xFFF,0x000,0x001.
REQ-034 SHALL cover: rst asserted after 2 of 4 beats, then new start -> no writes after reset, second run starts at element index 0.
REQ-035 SHALL cover: start with feat_len=0 -> done pulse, zero writes; start pulsed again while busy -> ignored.

Source files
------------

// File: rtl/act_writeback.sv
// Activation writeback: streams ReLU output beats into the activation buffer.
// Define ACT_WRITEBACK_MASK_EN to also pack per-element nonzero flags into a 32-bit mask buffer.
module act_writeback #(
    parameter int dataWidth = 32,
    parameter int addrWidth = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [15:0]          num_vertices,
    input  logic [9:0]           feat_len,
    input  logic [addrWidth-1:0] base_addr,
    input  logic                 a_valid,
    input  logic [dataWidth-1:0] a,
    output logic                 a_ready,
    output logic                 act_we,
    output logic [addrWidth-1:0] act_addr,
    output logic [dataWidth-1:0] act_wdata,
    output logic                 mask_we,
    output logic [addrWidth-1:0] mask_addr,
    output logic [31:0]          mask_wdata,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           dbg_state
);
    // Handshake: a beat transfers on a rising edge with a_valid && a_ready; a_ready is
    // high in every RUN cycle and a_valid may rise or fall in any cycle.
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2, DONE = 2'd3} state_t;

    state_t               state;
    logic [15:0]          nv_q;
    logic [15:0]          vtx;
    logic [9:0]           fl_q;
    logic [9:0]           elem;
    logic [addrWidth-1:0] base_q;
    logic [addrWidth-1:0] act_off;
    logic                 beat;
    logic                 last_elem;

    assign beat      = (state == RUN) && a_valid;
    assign last_elem = (elem == fl_q - 10'd1);
    assign a_ready   = (state == RUN);
    assign busy      = (state == RUN) || (state == FLUSH);
    assign done      = (state == DONE);
    assign dbg_state = state;

`ifndef ACT_WRITEBACK_MASK_EN
    logic last_vtx;
    assign last_vtx = (vtx + 16'd1 == nv_q);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            nv_q      <= '0;
            fl_q      <= '0;
            base_q    <= '0;
            vtx       <= '0;
            elem      <= '0;
            act_off   <= '0;
            act_we    <= 1'b0;
            act_addr  <= '0;
            act_wdata <= '0;
        end else begin
            act_we    <= 1'b0;
            act_addr  <= '0;
            act_wdata <= '0;
            case (state)
                IDLE: begin
                    if (start) begin
                        nv_q    <= num_vertices;
                        fl_q    <= feat_len;
                        base_q  <= base_addr;
                        vtx     <= '0;
                        elem    <= '0;
                        act_off <= '0;
                        // An empty layer still reports completion so the sequencer can move on.
                        state   <= (num_vertices == 16'd0 || feat_len == 10'd0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (beat) begin
                        act_we    <= 1'b1;
                        act_addr  <= base_q + act_off;
                        act_wdata <= a;
                        act_off   <= act_off + addrWidth'(1);
                        if (last_elem) begin
                            elem <= '0;
                            vtx  <= vtx + 16'd1;
`ifdef ACT_WRITEBACK_MASK_EN
                            state <= FLUSH;
`else
                            if (last_vtx) state <= DONE;
`endif
                        end else begin
                            elem <= elem + 10'd1;
                        end
                    end
                end
                FLUSH:   state <= (vtx == nv_q) ? DONE : RUN;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ACT_WRITEBACK_MASK_EN
    logic [31:0]          acc;
    logic [31:0]          acc_next;
    logic [4:0]           bit_cnt;
    logic [addrWidth-1:0] mask_off;

    assign acc_next = acc | ({31'd0, (a != '0)} << bit_cnt);

    // Each vertex's mask begins at bit 0 of a fresh word; FLUSH drains any partial word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc        <= '0;
            bit_cnt    <= '0;
            mask_off   <= '0;
            mask_we    <= 1'b0;
            mask_addr  <= '0;
            mask_wdata <= '0;
        end else begin
            mask_we    <= 1'b0;
            mask_addr  <= '0;
            mask_wdata <= '0;
            if (state == IDLE && start) begin
                acc      <= '0;
                bit_cnt  <= '0;
                mask_off <= '0;
            end else if (beat) begin
                if (bit_cnt == 5'd31) begin
                    mask_we    <= 1'b1;
                    mask_addr  <= base_q + mask_off;
                    mask_wdata <= acc_next;
                    mask_off   <= mask_off + addrWidth'(1);
                    acc        <= '0;
                    bit_cnt    <= '0;
                end else begin
                    acc     <= acc_next;
                    bit_cnt <= bit_cnt + 5'd1;
                end
            end else if (state == FLUSH && bit_cnt != 5'd0) begin
                mask_we    <= 1'b1;
                mask_addr  <= base_q + mask_off;
                mask_wdata <= acc;
                mask_off   <= mask_off + addrWidth'(1);
                acc        <= '0;
                bit_cnt    <= '0;
            end
        end
    end
`else
    assign mask_we    = 1'b0;
    assign mask_addr  = '0;
    assign mask_wdata = '0;
`endif

endmodule

// File: tb/tb_act_writeback.sv
// Bench for act_writeback: directed and random layers checked every cycle against a
// transaction-level model of activation/mask writes, handshake and status flags.
module tb_act_writeback;
  localparam int DW = 32;
  localparam int AW = 12;
`ifdef ACT_WRITEBACK_MASK_EN
  localparam bit MASK = 1'b1;
`else
  localparam bit MASK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [15:0]   num_vertices;
  logic [9:0]    feat_len;
  logic [AW-1:0] base_addr;
  logic          a_valid;
  logic [DW-1:0] a;
  logic          a_ready;
  logic          act_we;
  logic [AW-1:0] act_addr;
  logic [DW-1:0] act_wdata;
  logic          mask_we;
  logic [AW-1:0] mask_addr;
  logic [31:0]   mask_wdata;
  logic          busy;
  logic          done;
  logic [1:0]    dbg_state;

  act_writeback #(.dataWidth(DW), .addrWidth(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .num_vertices(num_vertices),
    .feat_len(feat_len), .base_addr(base_addr), .a_valid(a_valid), .a(a),
    .a_ready(a_ready), .act_we(act_we), .act_addr(act_addr), .act_wdata(act_wdata),
    .mask_we(mask_we), .mask_addr(mask_addr), .mask_wdata(mask_wdata),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // reference model state
  bit            run_active;
  bit            flush_now;
  bit            prev_hs;
  int            done_in;
  int            m_nv, m_fl, m_idx, m_vtx, m_mword;
  logic [AW-1:0] m_base;
  logic [DW-1:0] vbuf[$];
  logic [AW-1:0] exp_addr_q[$];
  logic [DW-1:0] exp_data_q[$];
  logic [AW-1:0] exp_maddr_q[$];
  logic [31:0]   exp_mdata_q[$];
  logic [AW-1:0] act_log_addr[$];
  logic [DW-1:0] act_log_data[$];
  logic [AW-1:0] mask_log_addr[$];
  logic [31:0]   mask_log_data[$];
  int            flush_cycles;
  logic [DW-1:0] beat_q[$];

  task automatic model_clear();
    run_active = 1'b0;
    flush_now  = 1'b0;
    prev_hs    = 1'b0;
    done_in    = -1;
    vbuf.delete();
    exp_addr_q.delete();
    exp_data_q.delete();
    exp_maddr_q.delete();
    exp_mdata_q.delete();
  endtask

  // Mask words for one finished vertex: bit j of the vertex lands in word j/32, bit j%32.
  task automatic push_mask_words();
    int nw;
    logic [31:0] w;
    nw = (m_fl + 31) / 32;
    for (int k = 0; k < nw; k++) begin
      w = '0;
      for (int j = 32 * k; j < m_fl && j < 32 * k + 32; j++)
        if (vbuf[j] != 0) w[j % 32] = 1'b1;
      exp_maddr_q.push_back(m_base + AW'(m_mword));
      exp_mdata_q.push_back(w);
      m_mword++;
    end
  endtask

  // scoreboard / compare process
  initial begin
    bit idle_m, exp_ready, exp_busy, hs;
    model_clear();
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("rst_ctl", {a_ready, busy, done, act_we, mask_we}, 0);
        chk("rst_act", {act_addr, act_wdata}, 0);
        chk("rst_mask", {mask_addr, mask_wdata}, 0);
        model_clear();
      end else begin
        idle_m    = !run_active && (done_in < 0);
        exp_ready = run_active && !flush_now;
        exp_busy  = run_active || (done_in == 1);
        chk("a_ready", a_ready, exp_ready);
        chk("busy", busy, exp_busy);
        chk("done", done, done_in == 0);
        if (busy && !a_ready) flush_cycles++;
        chk("act_we", act_we, prev_hs);
        if (act_we) begin
          act_log_addr.push_back(act_addr);
          act_log_data.push_back(act_wdata);
          chk("act_pending", exp_addr_q.size() != 0, 1);
          if (exp_addr_q.size() != 0) begin
            chk("act_addr", act_addr, exp_addr_q.pop_front());
            chk("act_wdata", act_wdata, exp_data_q.pop_front());
          end
        end else begin
          chk("act_idle_zero", {act_addr, act_wdata}, 0);
        end
`ifdef ACT_WRITEBACK_MASK_EN
        if (mask_we) begin
          mask_log_addr.push_back(mask_addr);
          mask_log_data.push_back(mask_wdata);
        end else begin
          chk("mask_idle_zero", {mask_addr, mask_wdata}, 0);
        end
`else
        chk("mask_tied", {mask_we, mask_addr, mask_wdata}, 0);
`endif
        if (done_in >= 0) done_in--;
        flush_now = 1'b0;
        hs = a_valid && exp_ready;
        prev_hs = hs;
        if (hs) begin
          exp_addr_q.push_back(m_base + AW'(m_idx));
          exp_data_q.push_back(a);
          vbuf.push_back(a);
          m_idx++;
          if (vbuf.size() == m_fl) begin
            push_mask_words();
            vbuf.delete();
            m_vtx++;
            if (m_vtx == m_nv) begin
              run_active = 1'b0;
              done_in = MASK ? 1 : 0;
            end else begin
              flush_now = MASK;
            end
          end
        end
        if (idle_m && start) begin
          m_nv = int'(num_vertices);
          m_fl = int'(feat_len);
          m_base = base_addr;
          m_idx = 0;
          m_vtx = 0;
          m_mword = 0;
          vbuf.delete();
          if (m_nv == 0 || m_fl == 0) done_in = 0;
          else run_active = 1'b1;
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    act_log_addr.delete();
    act_log_data.delete();
    mask_log_addr.delete();
    mask_log_data.delete();
    exp_maddr_q.delete();
    exp_mdata_q.delete();
    flush_cycles = 0;
  endtask

  task automatic make_beats(input int n, input bit all_nonzero);
    beat_q.delete();
    for (int i = 0; i < n; i++) begin
      if (all_nonzero) beat_q.push_back($urandom() | 32'h1);
      else beat_q.push_back(($urandom_range(0, 3) == 0) ? 32'h0 : $urandom());
    end
  endtask

  task automatic pulse_start(input int nv, input int fl, input logic [AW-1:0] base);
    num_vertices = 16'(nv);
    feat_len = 10'(fl);
    base_addr = base;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // mode 0: continuous valid, 1: valid every other cycle, 2: random valid.
  // poke >= 0 pulses a stray start with other parameters on that cycle.
  task automatic drive_beats(input int mode, input int poke);
    int sent = 0;
    int cyc = 0;
    while (sent < beat_q.size() && cyc < 4000) begin
      case (mode)
        0: a_valid = 1'b1;
        1: a_valid = (cyc % 2 == 0);
        default: a_valid = ($urandom_range(0, 3) != 0);
      endcase
      a = beat_q[sent];
      start = (cyc == poke);
      if (cyc == poke) begin
        num_vertices = 16'd1;
        feat_len = 10'd1;
        base_addr = 12'h0AA;
      end
      @(negedge clk);
      if (a_valid && a_ready) sent++;
      tick();
      cyc++;
    end
    start = 1'b0;
    a_valid = 1'b0;
    a = '0;
    chk("drive_all_beats", sent, beat_q.size());
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < 3000) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      tick();
      n++;
    end
    chk({name, "_done_seen"}, seen, 1);
  endtask

  task automatic finish_run(input string name);
    chk({name, "_act_drained"}, exp_addr_q.size(), 0);
`ifdef ACT_WRITEBACK_MASK_EN
    chk({name, "_mask_count"}, mask_log_addr.size(), exp_maddr_q.size());
    for (int i = 0; i < exp_maddr_q.size() && i < mask_log_addr.size(); i++) begin
      chk({name, "_mask_addr"}, mask_log_addr[i], exp_maddr_q[i]);
      chk({name, "_mask_wdata"}, mask_log_data[i], exp_mdata_q[i]);
    end
`endif
  endtask

  task automatic run_layer(input string name, input int nv, input int fl,
                           input logic [AW-1:0] base, input int mode, input int poke);
    clear_logs();
    pulse_start(nv, fl, base);
    drive_beats(mode, poke);
    wait_done(name);
    finish_run(name);
  endtask

  // main sequence
  initial begin
    logic [DW-1:0] t30_data[4];
    logic [AW-1:0] t33_addr[4];
    int nv, fl;
    rst = 1'b1;
    start = 1'b0;
    num_vertices = '0;
    feat_len = '0;
    base_addr = '0;
    a_valid = 1'b0;
    a = '0;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_a_ready", a_ready, 0);
    chk("reset_act_we", act_we, 0);
    chk("reset_state", dbg_state, 0);
    rst = 1'b1;
    tick();
    tick();

    // single vertex, mixed zero/nonzero, continuous stream
    t30_data = '{32'h3F800000, 32'h0, 32'h40000000, 32'h0};
    beat_q.delete();
    for (int i = 0; i < 4; i++) beat_q.push_back(t30_data[i]);
    run_layer("t30", 1, 4, 12'h100, 0, -1);
    chk("t30_act_n", act_log_addr.size(), 4);
    if (act_log_addr.size() == 4)
      for (int i = 0; i < 4; i++) begin
        chk("t30_addr", act_log_addr[i], 12'h100 + 12'(i));
        chk("t30_data", act_log_data[i], t30_data[i]);
      end
`ifdef ACT_WRITEBACK_MASK_EN
    chk("t30_mask_n", mask_log_addr.size(), 1);
    if (mask_log_addr.size() == 1)
      chk("t30_mask", {mask_log_addr[0], mask_log_data[0]}, {12'h100, 32'h00000005});
`endif

    // 40 nonzero elements: one full mask word plus an 8-bit tail
    make_beats(40, 1'b1);
    run_layer("t31", 1, 40, 12'h300, 0, -1);
    chk("t31_act_n", act_log_addr.size(), 40);
`ifdef ACT_WRITEBACK_MASK_EN
    chk("t31_mask_n", mask_log_addr.size(), 2);
    if (mask_log_addr.size() == 2) begin
      chk("t31_mask0", {mask_log_addr[0], mask_log_data[0]}, {12'h300, 32'hFFFFFFFF});
      chk("t31_mask1", {mask_log_addr[1], mask_log_data[1]}, {12'h301, 32'h000000FF});
    end
`endif

    // two vertices, valid every other cycle
    make_beats(6, 1'b0);
    run_layer("t32", 2, 3, 12'h040, 1, -1);
    chk("t32_act_n", act_log_addr.size(), 6);
    chk("t32_mask_n", mask_log_addr.size(), MASK ? 2 : 0);
    chk("t32_flush_cycles", flush_cycles, MASK ? 2 : 0);

    // address wrap at the top of the buffer
    make_beats(4, 1'b0);
    run_layer("t33", 1, 4, 12'hFFE, 2, -1);
    t33_addr = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
    chk("t33_act_n", act_log_addr.size(), 4);
    if (act_log_addr.size() == 4)
      for (int i = 0; i < 4; i++) chk("t33_addr", act_log_addr[i], t33_addr[i]);

    // reset after two of four beats, then a fresh layer
    clear_logs();
    make_beats(2, 1'b1);
    pulse_start(1, 4, 12'h200);
    drive_beats(0, -1);
    tick();
    tick();
    chk("t34_pre_writes", act_log_addr.size(), 2);
    rst = 1'b0;
    clear_logs();
    repeat (3) tick();
    rst = 1'b1;
    repeat (4) tick();
    chk("t34_no_writes", act_log_addr.size() + mask_log_addr.size(), 0);
    chk("t34_idle", busy, 0);
    make_beats(4, 1'b0);
    run_layer("t34", 1, 4, 12'h200, 0, -1);
    chk("t34_act_n", act_log_addr.size(), 4);
    if (act_log_addr.size() == 4) begin
      chk("t34_first_addr", act_log_addr[0], 12'h200);
      chk("t34_last_addr", act_log_addr[3], 12'h203);
    end

    // empty layers finish without writing
    clear_logs();
    pulse_start(2, 0, 12'h050);
    wait_done("t35_fl0");
    chk("t35_fl0_writes", act_log_addr.size() + mask_log_addr.size(), 0);
    clear_logs();
    pulse_start(0, 5, 12'h050);
    wait_done("t35_nv0");
    chk("t35_nv0_writes", act_log_addr.size() + mask_log_addr.size(), 0);

    // stray start while busy must not disturb the layer
    make_beats(6, 1'b0);
    run_layer("t35_ign", 1, 6, 12'h400, 0, 2);
    chk("t35_ign_act_n", act_log_addr.size(), 6);
    if (act_log_addr.size() == 6) chk("t35_ign_last", act_log_addr[5], 12'h405);
    tick();
    chk("t35_ign_idle", busy, 0);

    // random layers
    for (int r = 0; r < 6; r++) begin
      nv = $urandom_range(1, 3);
      fl = $urandom_range(1, 70);
      make_beats(nv * fl, 1'b0);
      run_layer("rand", nv, fl, 12'($urandom()), 2, -1);
      chk("rand_act_n", act_log_addr.size(), nv * fl);
    end

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
